// File: rtl/mem_lsu_pkg.sv
// Shared constants and types for the memory-stage load/store unit.
// Access sizes, FSM encodings and the latched write-back context live here.
package mem_lsu_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_RESP = 2'd2;

  // Context carried from acceptance until the response retires the access.
  typedef struct packed {
    logic [63:0] alu_result;
    logic [7:0]  byte_enable;
    logic        ext_un;
    logic        mem_to_reg;
  } lsu_pend_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_mask = 8'h01;
      MEM_SIZE_H: size_mask = 8'h03;
      MEM_SIZE_W: size_mask = 8'h0F;
      default:    size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational byte-lane alignment: strobes, shifted store data and the
// misalignment flag for one access within its doubleword.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic [63:0] rs2_data,
  output logic [7:0]  byte_enable,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic        misalign
);

  assign byte_enable = size_mask(mem_size);
  assign wmask       = byte_enable << addr_lo;
  assign wdata       = rs2_data << {addr_lo, 3'b000};

  // NOTE: every branch assigns misalign (default included) so no latch is inferred.
  always_comb begin
    misalign = 1'b0;
    case (mem_size)
      MEM_SIZE_H: misalign = addr_lo[0];
      MEM_SIZE_W: misalign = |addr_lo[1:0];
      MEM_SIZE_D: misalign = |addr_lo;
      default:    misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: one bus transaction per aligned load/store,
// pipeline stall while outstanding, registered write-back context.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] alu_result,
  input  logic [63:0] rs2_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_ext_un,
  output logic        stall_req,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [63:0] dbus_addr,
  output logic        dbus_wen,
  output logic [63:0] dbus_wdata,
  output logic [7:0]  dbus_wmask,
  input  logic        dbus_resp_valid,
  input  logic [63:0] dbus_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_mem_data,
  output logic [7:0]  wb_byte_enable,
  output logic        wb_mem_to_reg,
  output logic        wb_mem_ext_un,
  output logic        wb_misalign
);

  logic [1:0]  state;
  lsu_pend_t   pend;
  logic [7:0]  byte_enable;
  logic [7:0]  wmask;
  logic [63:0] wdata;
  logic        misalign;
  logic        is_mem;
  logic        mem_go;

  mem_align u_align (
    .addr_lo    (alu_result[2:0]),
    .mem_size   (mem_size),
    .rs2_data   (rs2_data),
    .byte_enable(byte_enable),
    .wmask      (wmask),
    .wdata      (wdata),
    .misalign   (misalign)
  );

  assign is_mem         = mem_ren | mem_wen;
  assign mem_go         = ex_valid & is_mem & ~misalign;
  assign dbus_req_valid = (state == LSU_REQ);

  // Stall releases in the response cycle so the next instruction enters on that edge.
  always_comb begin
    stall_req = 1'b1;
    case (state)
      LSU_IDLE: stall_req = mem_go;
      LSU_RESP: stall_req = ~dbus_resp_valid;
      default:  stall_req = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= LSU_IDLE;
      pend           <= '0;
      dbus_addr      <= '0;
      dbus_wen       <= 1'b0;
      dbus_wdata     <= '0;
      dbus_wmask     <= '0;
      wb_valid       <= 1'b0;
      wb_alu_result  <= '0;
      wb_mem_data    <= '0;
      wb_byte_enable <= '0;
      wb_mem_to_reg  <= 1'b0;
      wb_mem_ext_un  <= 1'b0;
      wb_misalign    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (mem_go) begin
            dbus_addr       <= {alu_result[63:3], 3'b000};
            dbus_wen        <= mem_wen & ~mem_ren;
            dbus_wdata      <= wdata;
            dbus_wmask      <= wmask;
            pend.alu_result <= alu_result;
            pend.byte_enable<= byte_enable;
            pend.ext_un     <= mem_ext_un;
            pend.mem_to_reg <= mem_ren;
            state           <= LSU_REQ;
          end else if (ex_valid) begin
            // Non-memory or misaligned: retire straight through without touching the bus.
            wb_valid       <= 1'b1;
            wb_alu_result  <= alu_result;
            wb_mem_data    <= '0;
            wb_byte_enable <= '0;
            wb_mem_to_reg  <= 1'b0;
            wb_mem_ext_un  <= 1'b0;
            wb_misalign    <= is_mem;
          end
        end
        LSU_REQ: begin
          if (dbus_req_ready) state <= LSU_RESP;
        end
        LSU_RESP: begin
          if (dbus_resp_valid) begin
            wb_valid       <= 1'b1;
            wb_alu_result  <= pend.alu_result;
            wb_mem_data    <= dbus_rdata;
            wb_byte_enable <= pend.byte_enable;
            wb_mem_to_reg  <= pend.mem_to_reg;
            wb_mem_ext_un  <= pend.ext_un;
            wb_misalign    <= 1'b0;
            state          <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a small scripted bus responder.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] alu_result;
  logic [63:0] rs2_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic        mem_ext_un;
  logic        stall_req;
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [63:0] dbus_addr;
  logic        dbus_wen;
  logic [63:0] dbus_wdata;
  logic [7:0]  dbus_wmask;
  logic        dbus_resp_valid;
  logic [63:0] dbus_rdata;
  logic        wb_valid;
  logic [63:0] wb_alu_result;
  logic [63:0] wb_mem_data;
  logic [7:0]  wb_byte_enable;
  logic        wb_mem_to_reg;
  logic        wb_mem_ext_un;
  logic        wb_misalign;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  mem_lsu dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .alu_result(alu_result),
    .rs2_data(rs2_data), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_ext_un(mem_ext_un), .stall_req(stall_req), .dbus_req_valid(dbus_req_valid),
    .dbus_req_ready(dbus_req_ready), .dbus_addr(dbus_addr), .dbus_wen(dbus_wen),
    .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask), .dbus_resp_valid(dbus_resp_valid),
    .dbus_rdata(dbus_rdata), .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .wb_byte_enable(wb_byte_enable),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_mem_ext_un(wb_mem_ext_un), .wb_misalign(wb_misalign)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_instr(input logic ren, input logic wen, input logic [1:0] size,
                           input logic ext, input logic [63:0] addr, input logic [63:0] data);
    ex_valid   = 1'b1;
    mem_ren    = ren;
    mem_wen    = wen;
    mem_size   = size;
    mem_ext_un = ext;
    alu_result = addr;
    rs2_data   = data;
  endtask

  // Holds the presented instruction while stalled, answers the bus after the
  // given wait counts, and returns once wb_valid is seen (called at edge+1).
  task automatic run_txn(input int req_wait, input int resp_wait, input logic [63:0] rdata,
                         output int lat, output int stall_cycles, output bit saw_req,
                         output bit stable, output bit last_stall,
                         output logic [63:0] c_addr, output logic [63:0] c_wdata,
                         output logic [7:0] c_wmask, output logic c_wen);
    bit accepted, acc_now, stall_now;
    int req_cnt, resp_cnt;
    lat = 0; stall_cycles = 0; saw_req = 0; stable = 1; last_stall = 0;
    accepted = 0; req_cnt = 0; resp_cnt = 0;
    c_addr = '0; c_wdata = '0; c_wmask = '0; c_wen = 1'b0;
    dbus_rdata = rdata;
    for (int c = 0; c < 64; c++) begin
      dbus_req_ready  = dbus_req_valid && (req_cnt >= req_wait);
      dbus_resp_valid = accepted && (resp_cnt >= resp_wait);
      #1;
      if (dbus_req_valid) begin
        if (!saw_req) begin
          c_addr = dbus_addr; c_wdata = dbus_wdata; c_wmask = dbus_wmask; c_wen = dbus_wen;
        end else if (c_addr !== dbus_addr || c_wdata !== dbus_wdata ||
                     c_wmask !== dbus_wmask || c_wen !== dbus_wen) begin
          stable = 0;
        end
        saw_req = 1;
      end
      stall_now  = stall_req;
      last_stall = stall_now;
      if (stall_now) stall_cycles++;
      acc_now = dbus_req_valid && dbus_req_ready;
      if (dbus_req_valid && !dbus_req_ready) req_cnt++;
      if (accepted && !dbus_resp_valid) resp_cnt++;
      @(posedge clock);
      lat++;
      #1;
      if (acc_now) accepted = 1;
      if (!stall_now) ex_valid = 1'b0;
      if (wb_valid) break;
    end
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b0;
  endtask

  initial begin
    int lat, stalls;
    bit saw_req, stable, last_stall;
    logic [63:0] c_addr, c_wdata;
    logic [7:0]  c_wmask;
    logic        c_wen;

    reset = 1'b1; ex_valid = 1'b0; alu_result = '0; rs2_data = '0; mem_ren = 1'b0;
    mem_wen = 1'b0; mem_size = MEM_SIZE_B; mem_ext_un = 1'b0;
    dbus_req_ready = 1'b0; dbus_resp_valid = 1'b0; dbus_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_alu", wb_alu_result, 0);
    check("rst_req_valid", dbus_req_valid, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_stall", stall_req, 0);
    reset = 1'b0;

    // ld, zero-wait bus
    set_instr(1, 0, MEM_SIZE_D, 0, 64'h8000_1008, 64'h0);
    run_txn(0, 0, 64'h1122334455667788, lat, stalls, saw_req, stable, last_stall,
            c_addr, c_wdata, c_wmask, c_wen);
    check("ld_latency", lat, 3);
    check("ld_wb_valid", wb_valid, 1);
    check("ld_mem_data", wb_mem_data, 64'h1122334455667788);
    check("ld_byte_en", wb_byte_enable, 8'hFF);
    check("ld_mem_to_reg", wb_mem_to_reg, 1);
    check("ld_alu", wb_alu_result, 64'h8000_1008);
    check("ld_stall_cycles", stalls, 2);
    check("ld_addr", c_addr, 64'h8000_1008);
    check("ld_wen", c_wen, 0);
    @(posedge clock); #1;
    check("ld_wb_pulse", wb_valid, 0);

    // sb 0xAB at byte 5
    set_instr(0, 1, MEM_SIZE_B, 0, 64'h8000_0005, 64'hAB);
    run_txn(0, 0, 64'h0, lat, stalls, saw_req, stable, last_stall,
            c_addr, c_wdata, c_wmask, c_wen);
    check("sb_addr", c_addr, 64'h8000_0000);
    check("sb_wmask", c_wmask, 8'h20);
    check("sb_wdata_lane", c_wdata[47:40], 8'hAB);
    check("sb_wdata", c_wdata, 64'h0000_AB00_0000_0000);
    check("sb_wen", c_wen, 1);
    check("sb_latency", lat, 3);
    check("sb_mem_to_reg", wb_mem_to_reg, 0);
    check("sb_byte_en", wb_byte_enable, 8'h01);

    // lw misaligned
    set_instr(1, 0, MEM_SIZE_W, 0, 64'h8000_0002, 64'h0);
    run_txn(0, 0, 64'h0, lat, stalls, saw_req, stable, last_stall,
            c_addr, c_wdata, c_wmask, c_wen);
    check("mis_latency", lat, 1);
    check("mis_flag", wb_misalign, 1);
    check("mis_mem_to_reg", wb_mem_to_reg, 0);
    check("mis_no_req", saw_req, 0);
    check("mis_no_stall", stalls, 0);

    // lhu with 4 ready-low cycles and 3 response-delay cycles
    set_instr(1, 0, MEM_SIZE_H, 1, 64'h8000_0016, 64'h0);
    run_txn(4, 3, 64'hCAFE_0000_0000_0000, lat, stalls, saw_req, stable, last_stall,
            c_addr, c_wdata, c_wmask, c_wen);
    check("lh_latency", lat, 10);
    check("lh_stable", stable, 1);
    check("lh_stall_cycles", stalls, 9);
    check("lh_stall_drop", last_stall, 0);
    check("lh_wmask", c_wmask, 8'hC0);
    check("lh_byte_en", wb_byte_enable, 8'h03);
    check("lh_ext_un", wb_mem_ext_un, 1);
    check("lh_data", wb_mem_data, 64'hCAFE_0000_0000_0000);
    check("lh_misalign", wb_misalign, 0);

    // add directly behind a load
    set_instr(1, 0, MEM_SIZE_D, 0, 64'h8000_0100, 64'h0);
    run_txn(0, 0, 64'h55, lat, stalls, saw_req, stable, last_stall,
            c_addr, c_wdata, c_wmask, c_wen);
    check("pre_add_ld_valid", wb_valid, 1);
    set_instr(0, 0, MEM_SIZE_B, 0, 64'h42, 64'h0);
    #1;
    check("add_no_stall", stall_req, 0);
    @(posedge clock); #1;
    ex_valid = 1'b0;
    check("add_wb_valid", wb_valid, 1);
    check("add_alu", wb_alu_result, 64'h42);
    check("add_mem_to_reg", wb_mem_to_reg, 0);

    // reset while in RESP, then a stray response
    set_instr(1, 0, MEM_SIZE_D, 0, 64'h8000_0200, 64'h0);
    @(posedge clock); #1;
    dbus_req_ready = 1'b1;
    @(posedge clock); #1;
    dbus_req_ready = 1'b0;
    check("rr_in_resp", dut.state, LSU_RESP);
    reset = 1'b1;
    ex_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rr_state", dut.state, LSU_IDLE);
    check("rr_addr", dbus_addr, 0);
    check("rr_wmask", dbus_wmask, 0);
    check("rr_wb_alu", wb_alu_result, 0);
    check("rr_wb_data", wb_mem_data, 0);
    dbus_resp_valid = 1'b1;
    dbus_rdata = 64'hDEAD_BEEF;
    #1;
    check("rr_stray_stall", stall_req, 0);
    @(posedge clock); #1;
    dbus_resp_valid = 1'b0;
    check("rr_stray_wb_valid", wb_valid, 0);
    check("rr_stray_data", wb_mem_data, 0);
    check("rr_stray_state", dut.state, LSU_IDLE);
    check("rr_req_valid", dbus_req_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit for the 64-bit core. It sits between the EX/MEM pipeline register and the write-back stage. It issues one data-bus transaction per load or store through a valid/ready request and response handshake, and stalls the pipeline while a transaction is outstanding. It registers the raw aligned doubleword, the unshifted byte-enable and the control bits that write-back needs to extract and extend load data.

## Interface
Parameters:
- none; widths come from `REG_BUS` (64 bits) in defines.v.

Ports:
- Clocking and reset:
  - clock  in  1  — the single clock.
  - reset  in  1  — synchronous, active-high.
- From EX/MEM:
  - ex_valid  in  1  — an instruction is present.
  - alu_result  in  64  — effective address, or the result for non-memory instructions.
  - rs2_data  in  64  — store data.
  - mem_ren  in  1  — instruction is a load.
  - mem_wen  in  1  — instruction is a store.
  - mem_size  in  2  — access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
  - mem_ext_un  in  1  — load is zero-extended.
- Pipeline control:
  - stall_req  out  1  — asks the pipeline to hold EX/MEM and earlier stages.
- Data bus:
  - dbus_req_valid  out  1  — request is valid.
  - dbus_req_ready  in  1  — bus accepts the request.
  - dbus_addr  out  64  — {alu_result[63:3], 3'b000}.
  - dbus_wen  out  1  — request is a write.
  - dbus_wdata  out  64  — shifted store data.
  - dbus_wmask  out  8  — byte strobes.
  - dbus_resp_valid  in  1  — response is valid.
  - dbus_rdata  in  64  — aligned read doubleword.
- To write-back (all registered):
  - wb_valid  out  1
  - wb_alu_result  out  64
  - wb_mem_data  out  64
  - wb_byte_enable  out  8
  - wb_mem_to_reg  out  1
  - wb_mem_ext_un  out  1
  - wb_misalign  out  1

## Operation
- byte_enable is derived from mem_size: 0x01, 0x03, 0x0F or 0xFF.
  - It goes to WB unshifted.
  - dbus_wmask = byte_enable << alu_result[2:0], truncated to 8 bits.
  - dbus_wdata = rs2_data << {alu_result[2:0], 3'b000}.
- An access is misaligned when alu_result is not a multiple of the access size.
  - A misaligned access never touches the bus.
  - It produces wb_valid=1, wb_misalign=1 and wb_mem_to_reg=0.
- FSM states: IDLE, REQ, RESP.
  - IDLE, when ex_valid is high and the access is an aligned mem_ren or mem_wen: latch the address, wdata, wmask, wen, byte_enable, ext_un and mem_to_reg, then go to REQ.
  - IDLE with any other valid instruction: it passes through to WB on the next edge.
  - REQ: dbus_req_valid=1. When dbus_req_ready is high, go to RESP. Request fields stay stable until accepted.
  - RESP: wait for dbus_resp_valid. Stores wait for it too (write acknowledge). On the response, capture dbus_rdata into wb_mem_data, set wb_valid=1 on that edge, and return to IDLE.
- stall_req = (state != IDLE) or (state == IDLE and ex_valid and an aligned memory op is present).
  - stall_req is combinational.
  - stall_req drops in the RESP cycle that sees dbus_resp_valid, so the next instruction is accepted on the following edge.
- wb_valid is a one-cycle pulse per retired instruction.
  - While stalled, wb_valid=0 (a bubble is inserted).
- dbus_resp_valid seen in IDLE or REQ is ignored.
- mem_ren and mem_wen both high is illegal; the instruction is treated as a load.

## Timing
- Reset values:
  - state = IDLE.
  - All wb_* outputs = 0.
  - dbus_req_valid, dbus_wen, dbus_wmask = 0; dbus_addr, dbus_wdata = 0.
  - stall_req reflects its combinational inputs only.
- Reset mid-transaction returns the FSM to IDLE and drops the transaction. The bus is reset by the same signal.
- Non-memory or misaligned instruction: latency is 1 cycle to wb_valid, with no stall.
- Load or store with zero-wait bus (ready in REQ, response the cycle after acceptance):
  - Cycle 0: accept in IDLE.
  - Cycle 1: REQ handshake.
  - Cycle 2: RESP.
  - Cycle 3: wb_valid.
  - Total: 3 edges. stall_req is high in cycles 0–1 and low in cycle 2.
- Each cycle dbus_req_ready or dbus_resp_valid stays low adds exactly one cycle.

## Structure
- Add to defines.v:
  - `MEM_SIZE_B/H/W/D` constants.
  - `LSU_IDLE/REQ/RESP` 2-bit encodings.
- One sub-module, mem_align, which is purely combinational. It maps (alu_result[2:0], mem_size, rs2_data) to byte_enable, dbus_wmask, dbus_wdata and misalign.
- The FSM and WB registers live in mem_lsu.

## Test plan
- ld at 0x80001008, bus ready immediately, rdata=0x1122334455667788 -> wb_valid on the 3rd edge after accept; wb_mem_data=0x1122334455667788; wb_byte_enable=0xFF; stall_req high for 2 cycles.
- sb rs2=0xAB at 0x80000005 -> dbus_addr=0x80000000, dbus_wmask=0x20, dbus_wdata[47:40]=0xAB, dbus_wen=1; wb_mem_to_reg=0 after the ack.
- lw at 0x80000002 -> wb_misalign=1 with no dbus_req_valid; 1-cycle latency; no stall.
- lh with dbus_req_ready held low 4 cycles and the response delayed 3 cycles -> dbus_req_valid and fields stable throughout; wb_valid exactly 7 cycles later than the zero-wait case; stall_req continuous until the response cycle.
- reset asserted in RESP, then a stray dbus_resp_valid after reset -> all outputs 0, state IDLE, the stray response ignored, wb_valid stays 0.
- add result 0x42 directly after a load -> the add is held by stall; wb_alu_result=0x42 with wb_valid one cycle after the load's wb_valid.
